// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch squash and
// multi-cycle multiply occupancy of EX, plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned REG_W   = 4,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_op1,
    input  logic [REG_W-1:0] ifid_op2,
    input  logic [REG_W-1:0] idex_op1,
    input  logic             idex_memread,
    input  logic             idex_is_mul,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {StRun, StMulWait, StMulDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;

    // Register 0 is hardwired zero, so a load targeting it never hazards.
    assign load_use = idex_memread && (idex_op1 != '0) &&
                      ((idex_op1 == ifid_op1) || (idex_op1 == ifid_op2));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mul_start    = 1'b0;
        mul_busy     = 1'b0;
        if (rst) begin
            state_d      = StRun;
            cnt_d        = '0;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (idex_is_mul) begin
                        mul_start    = 1'b1;
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                        state_d      = StMulWait;
                        cnt_d        = CW'(MUL_LAT - 1);
                    end else if (branch_taken) begin
                        // Squashing ID also removes any load-use dependency.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                StMulWait: begin
                    mul_busy     = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    cnt_d        = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = StMulDone;
                end
                StMulDone: begin
                    // The finishing mul is still in EX; idex_is_mul is not a new request.
                    state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MUL_LAT=4, CNT_W=4).
module tb_hazard_ctrl;

    localparam int unsigned REG_W   = 4;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 4;

    // Packed view: {pc_write, ifid_write, ifid_flush, idex_write,
    //               idex_bubble, exmem_bubble, mul_start, mul_busy}
    localparam logic [7:0] O_RESET   = 8'b0010_1100;
    localparam logic [7:0] O_NORMAL  = 8'b1101_0000;
    localparam logic [7:0] O_LOADUSE = 8'b0001_1000;
    localparam logic [7:0] O_BRANCH  = 8'b1111_1000;
    localparam logic [7:0] O_MULST   = 8'b0000_0110;
    localparam logic [7:0] O_MULWAIT = 8'b0000_0101;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] ifid_op1, ifid_op2, idex_op1;
    logic             idex_memread, idex_is_mul, branch_taken;
    logic             pc_write, ifid_write, ifid_flush, idex_write;
    logic             idex_bubble, exmem_bubble, mul_start, mul_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign outs = {pc_write, ifid_write, ifid_flush, idex_write,
                   idex_bubble, exmem_bubble, mul_start, mul_busy};

    hazard_ctrl #(
        .REG_W  (REG_W),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ifid_op1    (ifid_op1),
        .ifid_op2    (ifid_op2),
        .idex_op1    (idex_op1),
        .idex_memread(idex_memread),
        .idex_is_mul (idex_is_mul),
        .branch_taken(branch_taken),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_write  (idex_write),
        .idex_bubble (idex_bubble),
        .exmem_bubble(exmem_bubble),
        .mul_start   (mul_start),
        .mul_busy    (mul_busy),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs at the falling edge, let combinational outputs settle.
    task automatic drive(input logic mr, input logic [REG_W-1:0] d, input logic [REG_W-1:0] s1,
                         input logic [REG_W-1:0] s2, input logic mul, input logic br);
        @(negedge clk);
        idex_memread = mr;
        idex_op1     = d;
        ifid_op1     = s1;
        ifid_op2     = s2;
        idex_is_mul  = mul;
        branch_taken = br;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {idex_memread, idex_is_mul, branch_taken} = '0;
        {idex_op1, ifid_op1, ifid_op2} = '0;
        repeat (2) @(posedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("rst_outs", outs, O_RESET);
        check("rst_cnt", stall_cnt, 0);
        rst = 1'b0;
        #1;
        check("idle_outs", outs, O_NORMAL);
        post_edge();
        check("idle_cnt", stall_cnt, 0);

        // Load-use via op1
        drive(1, 2, 2, 0, 0, 0);
        check("lu_op1_outs", outs, O_LOADUSE);
        post_edge();
        check("lu_op1_cnt", stall_cnt, 1);
        // Reg 0 destination never hazards
        drive(1, 0, 0, 0, 0, 0);
        check("lu_r0_outs", outs, O_NORMAL);
        post_edge();
        check("lu_r0_cnt", stall_cnt, 1);
        // Load-use via op2
        drive(1, 2, 0, 2, 0, 0);
        check("lu_op2_outs", outs, O_LOADUSE);
        post_edge();
        check("lu_op2_cnt", stall_cnt, 2);
        drive(1, 3, 2, 2, 0, 0);
        check("lu_nomatch", outs, O_NORMAL);
        drive(0, 2, 2, 2, 0, 0);
        check("lu_noload", outs, O_NORMAL);

        // Branch wins over load-use
        drive(1, 2, 2, 0, 0, 1);
        check("br_outs", outs, O_BRANCH);
        post_edge();
        check("br_cnt", stall_cnt, 2);

        // Multiply held from cycle t
        drive(0, 0, 0, 0, 1, 0);
        check("mul_t0", outs, O_MULST);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            check($sformatf("mul_t%0d", i), outs, O_MULWAIT);
        end
        drive(0, 0, 0, 0, 1, 0);
        check("mul_done", outs, O_NORMAL);
        check("mul_cnt", stall_cnt, 6);
        drive(0, 0, 0, 0, 1, 0);
        check("mul2_start", outs, O_MULST);
        drive(0, 0, 0, 0, 1, 0);
        check("mul2_wait", outs, O_MULWAIT);
        drive(0, 0, 0, 0, 0, 0);
        check("mul2_wait2", outs, O_MULWAIT);
        check("mul2_cnt", stall_cnt, 8);

        // Asynchronous reset while in MULWAIT
        #1 rst = 1'b1;
        #1;
        check("rstmul_outs", outs, O_RESET);
        check("rstmul_cnt", stall_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rstmul_idle%0d", i), outs, O_NORMAL);
            post_edge();
        end
        check("rstmul_cnt2", stall_cnt, 0);

        // Saturation with a persistent hazard
        drive(1, 5, 0, 5, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            post_edge();
            check($sformatf("sat%0d", i), stall_cnt, (i > 15) ? 15 : i);
        end
        check("sat_outs", outs, O_LOADUSE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core; pairs with fwd_unit.
- Covers the hazards forwarding cannot resolve: load-use, taken-branch squash, multi-cycle multiply occupancy in EX.
- Drives PC, IF/ID, ID/EX and EX/MEM enables and bubbles; sequences the multiplier start pulse.
- Keeps a saturating stall-cycle counter.

Parameters:
- REG_W, 4, register-address width.
- MUL_LAT, 4, multiplier latency in cycles; must be at least 2.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ifid_op1  in  REG_W  source reg 1 of the instruction in ID.
- ifid_op2  in  REG_W  source reg 2 of the instruction in ID.
- idex_op1  in  REG_W  destination reg of the instruction in EX.
- idex_memread  in  1  instruction in EX is a load.
- idex_is_mul  in  1  instruction in EX is a multiply.
- branch_taken  in  1  branch in EX resolved taken.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_write  out  1  ID/EX load enable (0 = hold).
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_bubble  out  1  load NOP into EX/MEM.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_busy  out  1  multiplier in progress.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- States: RUN, MULWAIT, MULDONE; down-counter cnt of width ceil(log2(MUL_LAT)).
- While rst=1:
  - state=RUN, cnt=0, stall_cnt=0.
  - Outputs forced: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, mul_start=0, mul_busy=0.
  - Reset mid-multiply abandons it; no mul_start after release.
- Normal outputs (default): pc_write=ifid_write=idex_write=1; ifid_flush=idex_bubble=exmem_bubble=0; mul_start=0.
- Load-use hazard: idex_memread=1 and idex_op1!=0 and (idex_op1==ifid_op1 or idex_op1==ifid_op2). Reg 0 never hazards.
- RUN, evaluated combinationally in the same cycle, priority order:
  1. idex_is_mul=1:
     - Outputs: mul_start=1; pc_write=ifid_write=idex_write=0; exmem_bubble=1.
     - Next: MULWAIT, cnt=MUL_LAT-1.
     - branch_taken and load-use are ignored; both combinations are illegal with a mul in EX.
  2. branch_taken=1:
     - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
     - Load-use is suppressed because the ID instruction is squashed.
     - Stay RUN.
  3. load-use:
     - Outputs: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1.
     - Stay RUN. Exactly one stall cycle per hazard; a hazard persisting in the next cycle restalls.
  4. else normal outputs.
- MULWAIT:
  - Outputs: mul_busy=1; pc_write=ifid_write=idex_write=0; exmem_bubble=1; branch_taken and load-use ignored.
  - cnt decrements each cycle; when cnt==1, next state is MULDONE.
- MULDONE:
  - Normal outputs; mul_busy=0; idex_is_mul ignored (the same mul leaves EX now).
  - Next state RUN.
- Multiply timing: front-end hold lasts exactly MUL_LAT cycles (start cycle + MUL_LAT-1 MULWAIT cycles). The mul occupies EX for MUL_LAT+1 cycles.
- stall_cnt: on each clock edge with rst=0 and pc_write=0, increments by 1. Saturates at all-ones, with no wrap.
- Back-to-back muls:
  - The second mul reaches EX only after MULDONE, so it is seen in RUN and restarts normally.
  - A mul in ID during MULWAIT is held, not lost.

Test Plan:
- Reset: assert rst mid-cycle → all outputs at their forced reset values asynchronously, stall_cnt=0; deassert → normal outputs with inputs idle.
- Load-use: idex_memread=1, idex_op1=2, ifid_op1=2 → same cycle pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt 0→1. Repeat with idex_op1=0 → no stall. Repeat with ifid_op2=2 → stall.
- Branch priority: branch_taken=1 with the load-use condition also true → ifid_flush=1, idex_bubble=1, pc_write=1, stall_cnt unchanged.
- Multiply, MUL_LAT=4: idex_is_mul=1 held from cycle t →
  - mul_start=1 only at t.
  - pc_write=0 and exmem_bubble=1 for t..t+3; mul_busy=1 for t+1..t+3.
  - t+4: MULDONE, pc_write=1, exmem_bubble=0.
  - t+5: RUN; mul_start pulses again only if idex_is_mul is still high (next mul).
  - stall_cnt +4.
- Reset in MULWAIT: rst at t+2 → immediate RUN, mul_busy=0, stall_cnt=0, no further mul_start after release.
- Saturation: CNT_W=4, hold a load-use hazard for 20 cycles → stall_cnt reaches 0xF and stays.
